// File: rtl/fir_mac_sequencer.sv
// Serial multiplierless FIR: one tap at a time, coefficient consumed one nibble per cycle,
// each nonzero nibble selects an odd multiple from the external precomputer plus a shift.
module fir_mac_sequencer #(
  parameter int IN_DATA_WIDTH = 17,
  parameter int PC_WIDTH      = IN_DATA_WIDTH + 4,
  parameter int COEF_WIDTH    = 16,
  parameter int NTAPS         = 8,
  parameter int ACC_WIDTH     = IN_DATA_WIDTH + COEF_WIDTH + $clog2(NTAPS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [IN_DATA_WIDTH-1:0]    in_data,
  input  logic [NTAPS*COEF_WIDTH-1:0] coef_flat,
  output logic [IN_DATA_WIDTH-1:0]    pc_data,
  input  logic [PC_WIDTH-1:0]         pc_x1,
  input  logic [PC_WIDTH-1:0]         pc_x3,
  input  logic [PC_WIDTH-1:0]         pc_x5,
  input  logic [PC_WIDTH-1:0]         pc_x7,
  input  logic [PC_WIDTH-1:0]         pc_x9,
  input  logic [PC_WIDTH-1:0]         pc_x11,
  input  logic [PC_WIDTH-1:0]         pc_x13,
  input  logic [PC_WIDTH-1:0]         pc_x15,
  output logic                        y_valid,
  input  logic                        y_ready,
  output logic [ACC_WIDTH-1:0]        y_data,
  output logic                        busy
);

  localparam int NNIB  = COEF_WIDTH / 4;
  localparam int NIB_W = (NNIB > 1) ? $clog2(NNIB) : 1;
  localparam int TAP_W = $clog2(NTAPS);
  localparam int SH_W  = $clog2(ACC_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MAC, S_OUT} state_t;

  state_t                   state_q, state_d;
  logic [IN_DATA_WIDTH-1:0] delay_q [NTAPS];
  logic [COEF_WIDTH-1:0]    coef_q  [NTAPS];
  logic [ACC_WIDTH-1:0]     acc_q;
  logic [TAP_W-1:0]         tap_q;
  logic [NIB_W-1:0]         nib_q;
  logic [PC_WIDTH-1:0]      odd_mult [8];

  logic                     accept, last_nib, last_tap;
  logic [3:0]               digit;
  logic [1:0]               tz;
  logic [2:0]               mult_idx;
  logic [SH_W-1:0]          shift;
  logic [ACC_WIDTH-1:0]     addend;

  // Index k holds the multiple 2k+1 of pc_data.
  assign odd_mult[0] = pc_x1;
  assign odd_mult[1] = pc_x3;
  assign odd_mult[2] = pc_x5;
  assign odd_mult[3] = pc_x7;
  assign odd_mult[4] = pc_x9;
  assign odd_mult[5] = pc_x11;
  assign odd_mult[6] = pc_x13;
  assign odd_mult[7] = pc_x15;

  assign in_ready = (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);
  assign accept   = in_valid && in_ready;
  assign last_nib = (nib_q == NIB_W'(NNIB - 1));
  assign last_tap = (tap_q == TAP_W'(NTAPS - 1));

  // Nibble d = m * 2^tz with m odd; the addend is odd_mult[m] shifted into the nibble's weight.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    digit    = coef_q[tap_q][{nib_q, 2'b00} +: 4];
    tz       = 2'd0;
    casez (digit)
      4'b???1: tz = 2'd0;
      4'b??10: tz = 2'd1;
      4'b?100: tz = 2'd2;
      4'b1000: tz = 2'd3;
      default: tz = 2'd0;
    endcase
    mult_idx = 3'(digit >> ({1'b0, tz} + 3'd1));
    shift    = SH_W'({nib_q, 2'b00}) + SH_W'(tz);
    addend   = '0;
    if (digit != 4'd0) addend = ACC_WIDTH'(odd_mult[mult_idx]) << shift;
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_LOAD;
      S_LOAD:  state_d = S_MAC;
      S_MAC:   if (last_nib) state_d = last_tap ? S_OUT : S_LOAD;
      S_OUT:   if (y_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: delay line and coefficient arrays are reset as well, so a restart sees zero history.
      for (int i = 0; i < NTAPS; i++) begin
        delay_q[i] <= '0;
        coef_q[i]  <= '0;
      end
      acc_q   <= '0;
      tap_q   <= '0;
      nib_q   <= '0;
      pc_data <= '0;
      y_data  <= '0;
      y_valid <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            delay_q[0] <= in_data;
            for (int i = 1; i < NTAPS; i++) delay_q[i] <= delay_q[i-1];
            for (int i = 0; i < NTAPS; i++) coef_q[i] <= coef_flat[i*COEF_WIDTH +: COEF_WIDTH];
            acc_q <= '0;
            tap_q <= '0;
          end
        end
        S_LOAD: begin
          pc_data <= delay_q[tap_q];
          nib_q   <= '0;
        end
        S_MAC: begin
          acc_q <= acc_q + addend;
          nib_q <= nib_q + NIB_W'(1);
          if (last_nib) begin
            if (last_tap) begin
              y_data  <= acc_q + addend;
              y_valid <= 1'b1;
            end else begin
              tap_q <= tap_q + TAP_W'(1);
            end
          end
        end
        S_OUT: if (y_ready) y_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
